mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Initiator side of the byte-wide data memory interface, in the MEM stage of the pipelined CPU.
- Accepts one load/store request at a time from the pipeline (byte, halfword or word).
- Sequences it into per-byte Enable/ReadWrite transfers on a 256x8 RAM, big-endian, and returns assembled load data with a response strobe.

Parameters:
- ADDR_WIDTH, 8, RAM address width in bits (memory depth = 2**ADDR_WIDTH bytes).

Ports:
- Clk  input  1  rising-edge clock
- Reset_n  input  1  asynchronous active-low reset
- ReqValid  input  1  request present
- ReqReady  output  1  controller can accept a request
- ReqReadWrite  input  1  0 = load, 1 = store
- ReqSize  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- ReqSigned  input  1  sign-extend byte/halfword loads
- ReqAddress  input  32  byte address
- ReqDataIn  input  32  store data; the low bytes are used for byte/halfword stores
- RespValid  output  1  one-cycle pulse: access complete
- RespDataOut  output  32  load result; held until the next response
- RespError  output  1  valid with RespValid; only when MEM_ACCESS_ERR_EN is defined
- MemEnable  output  1  RAM enable
- MemReadWrite  output  1  RAM direction, 0 = read, 1 = write
- MemAddress  output  ADDR_WIDTH  RAM byte address
- MemDataIn  output  8  byte written to RAM
- MemDataOut  input  8  byte read from RAM; valid while MemEnable=1 with MemReadWrite=0

Behaviour:
- Reset values (asynchronous, while Reset_n=0):
  - FSM goes to IDLE; ReqReady=1.
  - RespValid=0, RespDataOut=0, RespError=0.
  - MemEnable=0, MemReadWrite=0, MemAddress=0, MemDataIn=0.
  - Byte counter = 0.
- Handshake:
  - A request is accepted on a rising edge with ReqValid=1 and ReqReady=1.
  - ReqReady=1 only in IDLE. All request fields are captured at acceptance; later changes on the request inputs are ignored.
- Byte count N = 1, 2 or 4 from ReqSize.
- Byte i address = ReqAddress[ADDR_WIDTH-1:0] + i, modulo 2**ADDR_WIDTH (wraps 255 -> 0).
- Upper address bits are ignored unless MEM_ACCESS_ERR_EN is defined.
- FSM:
  - IDLE -> SETUP on acceptance.
  - SETUP (MemEnable=0): drive MemAddress, MemReadWrite and MemDataIn for byte i -> ACCESS.
  - ACCESS (MemEnable=1, address/data held stable): on the clock edge ending ACCESS, loads capture MemDataOut into byte i of the assembly register.
    - If i < N-1: i++ and go to SETUP.
    - Otherwise go to DONE.
  - DONE: RespValid=1 for exactly one cycle, MemEnable=0 -> IDLE.
- Enable discipline: MemEnable returns low for one cycle between bytes, so the RAM sees a fresh Enable edge per byte.
- Endianness: big-endian.
  - Byte at the lowest address is the most significant byte of the access.
  - Word store writes ReqDataIn[31:24] first, to the base address.
  - Halfword store writes ReqDataIn[15:8] then ReqDataIn[7:0].
  - Byte store writes ReqDataIn[7:0].
- Load result is right-justified in RespDataOut.
  - Zero-extended if ReqSigned=0, sign-extended from bit 7/15 if ReqSigned=1.
  - ReqSigned is ignored for word loads and for stores.
- Stores: RespDataOut is left unchanged.
- Latency: acceptance at edge 0; RespValid high during the cycle after edge 2N+1. Byte = 3 cycles, halfword = 5, word = 9 cycles to response.
- Back-to-back: the next request can be accepted on the edge ending DONE's following IDLE cycle (ReqReady returns high in IDLE).
- Reset mid-operation: the access is aborted immediately, MemEnable drops asynchronously, and no RespValid is produced. Bytes already written stay written.

Optional Feature:
- MEM_ACCESS_ERR_EN defined:
  - A request is flagged at acceptance if it is misaligned (halfword with addr[0]=1; word with addr[1:0]!=0) or any ReqAddress[31:ADDR_WIDTH] bit is set.
  - A flagged request skips all RAM cycles: IDLE -> DONE.
  - Response: RespValid and RespError=1 in the cycle after acceptance; RespDataOut unchanged.
  - RespError=0 on all good responses.
- Not defined: RespError is tied to 0. No checks are made; misaligned accesses proceed byte-by-byte with address wrap.

Test Plan:
- Word store 0xDEADBEEF at 0x10, then word load 0x10:
  - RAM bytes [0x10..0x13] = DE AD BE EF.
  - RespDataOut = 0xDEADBEEF, RespValid 9 cycles after each acceptance.
- Byte 0x80 at 0x20:
  - Signed byte load -> 0xFFFFFF80.
  - Unsigned load -> 0x00000080.
  - Byte load latency 3 cycles.
- Halfword store 0x1234ABCD at 0x30 -> RAM[0x30]=0xAB, RAM[0x31]=0xCD; signed halfword load -> 0xFFFFABCD.
- Assert Reset_n=0 during the third ACCESS of a word store to 0x40:
  - MemEnable=0 immediately; no RespValid.
  - RAM[0x40..0x41] updated, RAM[0x43] untouched; ReqReady=1 after release.
- Hold ReqValid high with changing fields during a word load: only the first is accepted; ReqReady=0 for the whole access; exactly 4 MemEnable pulses seen.
- With MEM_ACCESS_ERR_EN, word load at 0x02:
  - RespValid and RespError=1 one cycle after acceptance; MemEnable never asserted.
  - Without the macro, the same request reads bytes 0x02..0x05.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Byte-serial, big-endian load/store sequencer between the MEM stage and a byte-wide RAM.
// Optional request checking (misalignment / out-of-range) is enabled by defining MEM_ACCESS_ERR_EN.
module mem_access_ctrl #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  ReqValid,
   output logic                  ReqReady,
   input  logic                  ReqReadWrite,
   input  logic [1:0]            ReqSize,
   input  logic                  ReqSigned,
   input  logic [31:0]           ReqAddress,
   input  logic [31:0]           ReqDataIn,
   output logic                  RespValid,
   output logic [31:0]           RespDataOut,
   output logic                  RespError,
   output logic                  MemEnable,
   output logic                  MemReadWrite,
   output logic [ADDR_WIDTH-1:0] MemAddress,
   output logic [7:0]            MemDataIn,
   input  logic [7:0]            MemDataOut
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                  state_r, state_s;
   logic [1:0]              idx_r, idx_s;
   logic [1:0]              last_r, last_s;
   logic [1:0]              cap_idx_r;
   logic                    rw_r, signed_r, err_r, err_s;
   logic [ADDR_WIDTH-1:0]   base_r, addr_s;
   logic [31:0]             data_r, asm_r, asm_s;
   logic [1:0]              slot_s, cap_slot_s;
   logic [7:0]              wbyte_s;
   logic                    accept_s;

   // Right-justify and extend an assembled load of (last+1) bytes.
   function automatic logic [31:0] extend(input logic [31:0] a, input logic [1:0] last,
                                          input logic sgn);
      logic [31:0] r;
      case (last)
         2'd0:    r = sgn ? {{24{a[7]}}, a[7:0]} : {24'd0, a[7:0]};
         2'd1:    r = sgn ? {{16{a[15]}}, a[15:0]} : {16'd0, a[15:0]};
         default: r = a;
      endcase
      return r;
   endfunction

   assign accept_s   = ReqValid & ReqReady;
   assign addr_s     = base_r + ADDR_WIDTH'(idx_r);
   assign slot_s     = last_r - idx_r;
   assign wbyte_s    = data_r[{slot_s, 3'b000} +: 8];
   assign cap_slot_s = last_r - cap_idx_r;

   // Byte count (minus one) from the request size; reserved size behaves as word.
   always_comb begin
      case (ReqSize)
         2'b00:   last_s = 2'd0;
         2'b01:   last_s = 2'd1;
         default: last_s = 2'd3;
      endcase
   end

`ifdef MEM_ACCESS_ERR_EN
   // Flag misaligned or out-of-range requests at acceptance.
   always_comb begin
      if ((ReqSize == 2'b01) && ReqAddress[0]) begin
         err_s = 1'b1;
      end else if (ReqSize[1] && (ReqAddress[1:0] != 2'b00)) begin
         err_s = 1'b1;
      end else begin
         err_s = |ReqAddress[31:ADDR_WIDTH];
      end
   end
`else
   logic unused_addr_s;
   assign unused_addr_s = ^ReqAddress[31:ADDR_WIDTH];
   assign err_s         = 1'b0;
`endif

   // Next-state and byte index sequencing.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               idx_s   = 2'd0;
               state_s = err_s ? DONE : SETUP;
            end else begin
               state_s = IDLE;
            end
         end
         SETUP:  state_s = ACCESS;
         ACCESS: begin
            if (idx_r == last_r) begin
               state_s = DONE;
            end else begin
               idx_s   = idx_r + 2'd1;
               state_s = SETUP;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Merge a RAM read byte into its big-endian slot of the assembly value.
   always_comb begin
      asm_s = asm_r;
      if (MemEnable && !MemReadWrite) begin
         asm_s[{cap_slot_s, 3'b000} +: 8] = MemDataOut;
      end else begin
         asm_s = asm_r;
      end
   end

   // State register and byte index.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r <= IDLE;
         idx_r   <= 2'd0;
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
      end
   end

   // Request capture; later changes on the request inputs are ignored.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rw_r     <= 1'b0;
         signed_r <= 1'b0;
         err_r    <= 1'b0;
         last_r   <= 2'd0;
         base_r   <= '0;
         data_r   <= 32'd0;
      end else if (accept_s) begin
         rw_r     <= ReqReadWrite;
         signed_r <= ReqSigned;
         err_r    <= err_s;
         last_r   <= last_s;
         base_r   <= ReqAddress[ADDR_WIDTH-1:0];
         data_r   <= ReqDataIn;
      end
   end

   // Registered interface outputs; RAM signals follow the FSM by one cycle.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ReqReady     <= 1'b1;
         RespValid    <= 1'b0;
         RespDataOut  <= 32'd0;
         RespError    <= 1'b0;
         MemEnable    <= 1'b0;
         MemReadWrite <= 1'b0;
         MemAddress   <= '0;
         MemDataIn    <= 8'd0;
         cap_idx_r    <= 2'd0;
         asm_r        <= 32'd0;
      end else begin
         // Ready stays low through the response cycle and returns one cycle later.
         ReqReady  <= (state_s == IDLE) && (state_r != DONE);
         MemEnable <= (state_r == ACCESS);
         RespValid <= (state_r == DONE);
         asm_r     <= asm_s;
`ifdef MEM_ACCESS_ERR_EN
         RespError <= (state_r == DONE) && err_r;
`else
         RespError <= 1'b0;
`endif
         if (state_r == SETUP) begin
            MemAddress   <= addr_s;
            MemReadWrite <= rw_r;
            MemDataIn    <= wbyte_s;
            cap_idx_r    <= idx_r;
         end
         if ((state_r == DONE) && !rw_r && !err_r) begin
            RespDataOut <= extend(asm_s, last_r, signed_r);
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 256x8 RAM.
module tb_mem_access_ctrl;

   logic        Clk, Reset_n, ReqValid, ReqReady, ReqReadWrite, ReqSigned;
   logic [1:0]  ReqSize;
   logic [31:0] ReqAddress, ReqDataIn, RespDataOut;
   logic        RespValid, RespError, MemEnable, MemReadWrite;
   logic [7:0]  MemAddress, MemDataIn, MemDataOut;

   logic [7:0]  ram [256];
   logic        ram_load;
   int          n_cmp = 0;
   int          n_err = 0;

   mem_access_ctrl #(.ADDR_WIDTH(8)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqReadWrite(ReqReadWrite),
      .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddress(ReqAddress),
      .ReqDataIn(ReqDataIn), .RespValid(RespValid), .RespDataOut(RespDataOut),
      .RespError(RespError), .MemEnable(MemEnable), .MemReadWrite(MemReadWrite),
      .MemAddress(MemAddress), .MemDataIn(MemDataIn), .MemDataOut(MemDataOut)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // RAM model: preload ram[i]=i, synchronous write, combinational read.
   always @(posedge Clk) begin
      if (ram_load) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
      end else if (MemEnable && MemReadWrite) begin
         ram[MemAddress] <= MemDataIn;
      end
   end
   assign MemDataOut = ram[MemAddress];

   initial begin
      #300000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ram4(input int a);
      return {ram[a], ram[a+1], ram[a+2], ram[a+3]};
   endfunction

   // One request with ReqValid dropped after acceptance; checks latency and handshake.
   task automatic do_req(input string tag, input logic rw, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] din,
                         input int exp_lat, input int exp_pulses,
                         output logic [31:0] rdata, output logic rerr);
      int  lat, pulses, w;
      logic rdy_bad, done;
      @(negedge Clk);
      ReqValid = 1'b1; ReqReadWrite = rw; ReqSize = size; ReqSigned = sgn;
      ReqAddress = addr; ReqDataIn = din;
      w = 0;
      while (!ReqReady && w < 20) begin
         @(negedge Clk);
         w++;
      end
      @(posedge Clk);
      #1 ReqValid = 1'b0;
      check({tag, ":rdy_drop"}, 32'(ReqReady), 32'd0);
      lat = 0; pulses = 0; rdy_bad = 1'b0; done = 1'b0;
      for (int k = 1; k <= 40 && !done; k++) begin
         @(posedge Clk);
         #1;
         if (MemEnable) pulses++;
         if (RespValid) begin
            done = 1'b1;
            lat  = k;
         end else if (ReqReady) begin
            rdy_bad = 1'b1;
         end
      end
      rdata = RespDataOut;
      rerr  = RespError;
      check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
      check({tag, ":pulses"}, 32'(pulses), 32'(exp_pulses));
      check({tag, ":rdy_busy"}, {31'd0, rdy_bad | ReqReady}, 32'd0);
      @(posedge Clk);
      #1;
      check({tag, ":resp_pulse"}, 32'(RespValid), 32'd0);
      check({tag, ":rdy_back"}, 32'(ReqReady), 32'd1);
   endtask

   logic [31:0] rd;
   logic        re;
   int          lat, pulses;
   logic        done, rdy_bad;

   initial begin
      Reset_n = 1'b0; ram_load = 1'b1; ReqValid = 1'b0; ReqReadWrite = 1'b0;
      ReqSize = 2'b00; ReqSigned = 1'b0; ReqAddress = 32'd0; ReqDataIn = 32'd0;
      repeat (3) @(posedge Clk);
      #1 ram_load = 1'b0;
      check("rst:ReqReady", 32'(ReqReady), 32'd1);
      check("rst:RespValid", 32'(RespValid), 32'd0);
      check("rst:RespDataOut", RespDataOut, 32'd0);
      check("rst:RespError", 32'(RespError), 32'd0);
      check("rst:MemEnable", 32'(MemEnable), 32'd0);
      check("rst:MemReadWrite", 32'(MemReadWrite), 32'd0);
      check("rst:MemAddress", 32'(MemAddress), 32'd0);
      check("rst:MemDataIn", 32'(MemDataIn), 32'd0);
      @(negedge Clk) Reset_n = 1'b1;

      do_req("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 9, 4, rd, re);
      check("sw10:ram", ram4(32'h10), 32'hDEADBEEF);
      check("sw10:data", rd, 32'd0);
      check("sw10:err", 32'(re), 32'd0);

      do_req("lw10", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 9, 4, rd, re);
      check("lw10:data", rd, 32'hDEADBEEF);

      do_req("sb20", 1'b1, 2'b00, 1'b0, 32'h20, 32'h12345680, 3, 1, rd, re);
      check("sb20:ram", 32'(ram[32'h20]), 32'h80);
      check("sb20:neighbour", 32'(ram[32'h21]), 32'h21);
      check("sb20:data_held", rd, 32'hDEADBEEF);

      do_req("lbs20", 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 3, 1, rd, re);
      check("lbs20:data", rd, 32'hFFFFFF80);
      do_req("lbu20", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 3, 1, rd, re);
      check("lbu20:data", rd, 32'h00000080);

      do_req("sh30", 1'b1, 2'b01, 1'b0, 32'h30, 32'h1234ABCD, 5, 2, rd, re);
      check("sh30:ram", ram4(32'h30), 32'hABCD3233);
      check("sh30:data_held", rd, 32'h00000080);
      do_req("lhs30", 1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 5, 2, rd, re);
      check("lhs30:data", rd, 32'hFFFFABCD);
      do_req("lhu30", 1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 5, 2, rd, re);
      check("lhu30:data", rd, 32'h0000ABCD);

`ifdef MEM_ACCESS_ERR_EN
      do_req("lw110", 1'b0, 2'b10, 1'b0, 32'h110, 32'h0, 1, 0, rd, re);
      check("lw110:err", 32'(re), 32'd1);
      check("lw110:data_held", rd, 32'h0000ABCD);
      do_req("lw02", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1, 0, rd, re);
      check("lw02:err", 32'(re), 32'd1);
      check("lw02:data_held", rd, 32'h0000ABCD);
      do_req("lhff", 1'b0, 2'b01, 1'b0, 32'hFF, 32'h0, 1, 0, rd, re);
      check("lhff:err", 32'(re), 32'd1);
      check("lhff:data_held", rd, 32'h0000ABCD);
`else
      do_req("lw110", 1'b0, 2'b10, 1'b0, 32'h110, 32'h0, 9, 4, rd, re);
      check("lw110:data", rd, 32'hDEADBEEF);
      check("lw110:err", 32'(re), 32'd0);
      do_req("lw02", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 9, 4, rd, re);
      check("lw02:data", rd, 32'h02030405);
      do_req("lhff", 1'b0, 2'b01, 1'b0, 32'hFF, 32'h0, 5, 2, rd, re);
      check("lhff:data_wrap", rd, 32'h0000FF00);
`endif

      // ReqValid held high while the request fields keep changing.
      @(negedge Clk);
      ReqValid = 1'b1; ReqReadWrite = 1'b0; ReqSize = 2'b10; ReqSigned = 1'b0;
      ReqAddress = 32'h10; ReqDataIn = 32'h0;
      @(posedge Clk);
      #1;
      lat = 0; pulses = 0; done = 1'b0; rdy_bad = ReqReady;
      for (int k = 1; k <= 40 && !done; k++) begin
         ReqAddress = 32'h50 + 32'(k); ReqReadWrite = 1'b1;
         ReqSize = 2'(k); ReqDataIn = $urandom;
         @(posedge Clk);
         #1;
         if (MemEnable) pulses++;
         if (RespValid) begin
            done = 1'b1;
            lat = k;
            ReqValid = 1'b0;
         end else if (ReqReady) begin
            rdy_bad = 1'b1;
         end
      end
      ReqValid = 1'b0; ReqReadWrite = 1'b0;
      check("hold:latency", 32'(lat), 32'd9);
      check("hold:pulses", 32'(pulses), 32'd4);
      check("hold:rdy_busy", 32'(rdy_bad), 32'd0);
      check("hold:data", RespDataOut, 32'hDEADBEEF);
      @(posedge Clk);
      #1;
      check("hold:resp_pulse", 32'(RespValid), 32'd0);
      repeat (3) @(posedge Clk);
      #1;
      check("hold:no_store", ram4(32'h50), 32'h50515253);

      // Reset asserted during the third RAM enable of a word store.
      @(negedge Clk);
      ReqValid = 1'b1; ReqReadWrite = 1'b1; ReqSize = 2'b10; ReqSigned = 1'b0;
      ReqAddress = 32'h40; ReqDataIn = 32'hCAFEF00D;
      @(posedge Clk);
      #1 ReqValid = 1'b0;
      repeat (6) @(posedge Clk);
      #2;
      check("rstmid:enable_before", 32'(MemEnable), 32'd1);
      Reset_n = 1'b0;
      #1;
      check("rstmid:enable_drop", 32'(MemEnable), 32'd0);
      rdy_bad = 1'b0;
      repeat (3) begin
         @(posedge Clk);
         #1;
         if (RespValid) rdy_bad = 1'b1;
      end
      @(negedge Clk) Reset_n = 1'b1;
      repeat (12) begin
         @(posedge Clk);
         #1;
         if (RespValid || MemEnable) rdy_bad = 1'b1;
      end
      check("rstmid:no_resp", 32'(rdy_bad), 32'd0);
      check("rstmid:rdy", 32'(ReqReady), 32'd1);
      check("rstmid:ram", ram4(32'h40), 32'hCAFE4243);
      check("rstmid:data", RespDataOut, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
